// File: rtl/answer_checker.sv
// Debounces the player switches and scores them against three falling
// letters; pulses correct on a match and latches game_over at the floor.
//
// Ports:
//   CLOCK_50      system clock, rising edge
//   reset_button  async active-low reset
//   SW            raw player switches, asynchronous to CLOCK_50
//   letter1..3    target byte of each column
//   ypos1..3      current row of each column
//   active        bit i high: column i+1 holds a live letter
//   correct       one-cycle pulse, bit i: column i+1 matched
//   game_over     sticky end-of-game flag
//   accepted      last debounced switch value
module answer_checker #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int YPOS_FLOOR      = 29
) (
  input  logic       CLOCK_50,
  input  logic       reset_button,
  input  logic [7:0] SW,
  input  logic [7:0] letter1,
  input  logic [7:0] letter2,
  input  logic [7:0] letter3,
  input  logic [4:0] ypos1,
  input  logic [4:0] ypos2,
  input  logic [4:0] ypos3,
  input  logic [2:0] active,
  output logic [2:0] correct,
  output logic       game_over,
  output logic [7:0] accepted
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [4:0] FLOOR = 5'(YPOS_FLOOR);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    FIRE,
    HOLD,
    OVER
  } state_t;

  state_t state, state_d;

  logic [7:0]    sync1, sync2, sw_prev;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    acc_q;
  logic [2:0]    match, match_q;
  logic          floor_hit;
  logic          load;

  assign accepted  = acc_q;
  assign game_over = (state == OVER);

  always_comb begin
    match = active & {letter3 == acc_q,
                      letter2 == acc_q,
                      letter1 == acc_q};
    floor_hit = |(active & {ypos3 >= FLOOR,
                            ypos2 >= FLOOR,
                            ypos1 >= FLOOR});
  end

  always_comb begin
    cnt_d = cnt;
    if (sync2 != sw_prev)
      cnt_d = '0;
    else if (cnt != CMAX)
      cnt_d = cnt + 1'b1;
  end

  // SETTLE leaves on the same edge the counter reaches its limit,
  // which gives 2 + DEBOUNCE_CYCLES + 2 cycles from SW edge to pulse.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    correct = '0;
    case (state)
      IDLE: begin
        if (sync2 != acc_q)
          state_d = SETTLE;
      end
      SETTLE: begin
        if (sync2 == acc_q) begin
          state_d = IDLE;
        end else if (cnt_d == CMAX) begin
          state_d = CHECK;
          load    = 1'b1;
        end
      end
      CHECK: begin
        state_d = (|match) ? FIRE : IDLE;
      end
      FIRE: begin
        correct = match_q;
        state_d = HOLD;
      end
      HOLD: begin
        if (sync2 != acc_q)
          state_d = SETTLE;
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The floor wins over any scoring in flight.
    if (state != OVER && floor_hit) begin
      state_d = OVER;
      load    = 1'b0;
      correct = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_button) begin
    if (!reset_button) begin
      sync1   <= '0;
      sync2   <= '0;
      sw_prev <= '0;
      cnt     <= '0;
      state   <= IDLE;
      acc_q   <= '0;
      match_q <= '0;
    end else begin
      sync1   <= SW;
      sync2   <= sync1;
      sw_prev <= sync2;
      cnt     <= cnt_d;
      state   <= state_d;
      if (load)
        acc_q <= sync2;
      if (state == CHECK)
        match_q <= match;
    end
  end

endmodule
